// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and constants for the LC-3 unified memory port arbiter.
package lc3_mem_pkg;

   localparam int ADDR_W    = 16;
   localparam int DATA_W    = 16;
   localparam int NUM_PORTS = 3;

   localparam int PORT_TB    = 0;
   localparam int PORT_DATA  = 1;
   localparam int PORT_FETCH = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled into one interface.
interface lc3_mem_arbiter_if
   import lc3_mem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = ADDR_W,
   parameter int DATA_WIDTH    = DATA_W,
   parameter int NUM_REQ       = NUM_PORTS
);

   logic [NUM_REQ-1:0]                    req;
   logic [NUM_REQ-1:0]                    req_we;
   logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata;
   logic [NUM_REQ-1:0]                    gnt;
   logic [NUM_REQ-1:0]                    done;
   logic                                  err;
   logic [DATA_WIDTH-1:0]                 rdata;

   logic                                  mem_req;
   logic                                  mem_we;
   logic [ADDRESS_WIDTH-1:0]              mem_addr;
   logic [DATA_WIDTH-1:0]                 mem_wdata;
   logic                                  mem_ready;
   logic [DATA_WIDTH-1:0]                 mem_rdata;

   // master = the arbiter; slave = requesters plus the memory model
   modport master (
      input  req, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
      output gnt, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output req, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
      input  gnt, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lc3_rr_picker.sv
// Combinational round-robin picker: first eligible bit above last_idx, wrapping.
module lc3_rr_picker #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] last_idx,
   output logic [N-1:0]     winner_oh,
   output logic [IDX_W-1:0] winner_idx,
   output logic             valid
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

   logic [IDX_W-1:0] scan;
   logic             found;

   // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      winner_oh  = '0;
      winner_idx = '0;
      found      = 1'b0;
      scan       = last_idx;
      for (int i = 0; i < N; i++) begin
         scan = (scan == IDX_LAST) ? '0 : scan + IDX_W'(1);
         if (!found && eligible[scan]) begin
            found             = 1'b1;
            winner_oh[scan]   = 1'b1;
            winner_idx        = scan;
         end
      end
   end

   assign valid = |eligible;

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Round-robin arbiter sharing the single LC-3 memory port; one transaction in flight with watchdog.
module lc3_mem_arbiter
   import lc3_mem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = ADDR_W,
   parameter int DATA_WIDTH    = DATA_W,
   parameter int NUM_REQ       = NUM_PORTS,
   parameter int TIMEOUT       = 64
) (
   input  logic              clk,
   input  logic              reset,
   lc3_mem_arbiter_if.master bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   arb_state_t               state_q,     state_d;
   logic [NUM_REQ-1:0]       gnt_q,       gnt_d;
   logic [NUM_REQ-1:0]       done_q,      done_d;
   logic                     err_q,       err_d;
   logic [DATA_WIDTH-1:0]    rdata_q,     rdata_d;
   logic                     mem_req_q,   mem_req_d;
   logic                     mem_we_q,    mem_we_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic [IDX_W-1:0]         owner_q,     owner_d;
   logic [IDX_W-1:0]         last_q,      last_d;
   logic [TMR_W-1:0]         timer_q,     timer_d;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;
   logic               finish;

   // A requester in its done cycle is masked so it cannot be re-granted immediately.
   assign eligible = bus.req & ~done_q;

   lc3_rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .eligible   (eligible),
      .last_idx   (last_q),
      .winner_oh  (pick_oh),
      .winner_idx (pick_idx),
      .valid      (pick_valid)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      owner_d     = owner_q;
      last_d      = last_q;
      timer_d     = timer_q;
      finish      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d     = BUSY;
               gnt_d       = pick_oh;
               mem_req_d   = 1'b1;
               mem_we_d    = bus.req_we[pick_idx];
               mem_addr_d  = bus.req_addr[pick_idx];
               mem_wdata_d = bus.req_wdata[pick_idx];
               owner_d     = pick_idx;
               timer_d     = '0;
            end
         end
         BUSY: begin
            if (bus.mem_ready) begin
               finish = 1'b1;
               if (!mem_we_q) rdata_d = bus.mem_rdata;
            end else if (timer_q == TMR_LAST) begin
               finish = 1'b1;
               err_d  = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
            if (finish) begin
               done_d    = gnt_q;
               gnt_d     = '0;
               mem_req_d = 1'b0;
               last_d    = owner_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         owner_q     <= '0;
         last_q      <= IDX_LAST;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         timer_q     <= timer_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // Protocol and invariant properties.
   a_gnt_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
   a_done_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(done_q));
   a_gnt_memreq:  assert property (@(posedge clk) disable iff (reset) (|gnt_q) |-> mem_req_q);
   a_req_held:    assert property (@(posedge clk) disable iff (reset) (state_q == BUSY) |-> bus.req[owner_q]);
   a_ready_idle:  assert property (@(posedge clk) disable iff (reset) (state_q == IDLE) |-> !bus.mem_ready);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter: vector table plus multi-cycle corner-case sequences.
module tb_lc3_mem_arbiter;
   import lc3_mem_pkg::*;

   localparam int AW  = 16;
   localparam int DW  = 16;
   localparam int NR  = 3;
   localparam int TMO = 64;

   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            lat;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   lc3_mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

   lc3_mem_arbiter #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .NUM_REQ       (NR),
      .TIMEOUT       (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Memory model: answers after mem_lat cycles of mem_req (0 = never answers).
   int            mem_lat = 1;
   int            mem_cnt;
   logic [DW-1:0] mem_arr [logic [AW-1:0]];

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : ~a;
   endfunction

   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      mem_cnt       = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_req && !reset) begin
            mem_cnt = mem_cnt + 1;
            if (mem_lat != 0 && mem_cnt == mem_lat) begin
               bus.mem_ready = 1'b1;
               if (bus.mem_we) begin
                  mem_arr[bus.mem_addr] = bus.mem_wdata;
                  bus.mem_rdata         = 16'hDEAD;
               end else begin
                  bus.mem_rdata = model_read(bus.mem_addr);
               end
            end else begin
               bus.mem_ready = 1'b0;
            end
         end else begin
            mem_cnt       = 0;
            bus.mem_ready = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_we[p]    = we;
      bus.req_addr[p]  = a;
      bus.req_wdata[p] = d;
      bus.req[p]       = 1'b1;
   endtask

   task automatic wait_done(output int cycles, input int budget);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (bus.done == '0 && cycles < budget);
   endtask

   vec_t vecs [6];

   initial begin
      int cyc;
      int total;
      int hi_cnt;
      logic stable;
      int order [4];

      mem_arr[16'h3000] = 16'h1234;

      // port, we, addr, wdata, mem latency, expected rdata after done
      vecs[0] = '{port: PORT_FETCH, we: 1'b0, addr: 16'h3000, wdata: 16'h0000, lat: 1, exp_rdata: 16'h1234};
      vecs[1] = '{port: PORT_DATA,  we: 1'b1, addr: 16'h4000, wdata: 16'hBEEF, lat: 2, exp_rdata: 16'h1234};
      vecs[2] = '{port: PORT_TB,    we: 1'b0, addr: 16'h4000, wdata: 16'h1111, lat: 1, exp_rdata: 16'hBEEF};
      vecs[3] = '{port: PORT_DATA,  we: 1'b0, addr: 16'h0010, wdata: 16'h2222, lat: 3, exp_rdata: 16'hFFEF};
      vecs[4] = '{port: PORT_TB,    we: 1'b1, addr: 16'h0010, wdata: 16'h0077, lat: 1, exp_rdata: 16'hFFEF};
      vecs[5] = '{port: PORT_FETCH, we: 1'b0, addr: 16'h0010, wdata: 16'h3333, lat: 4, exp_rdata: 16'h0077};

      reset         = 1'b1;
      bus.req       = '0;
      bus.req_we    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);

      check("reset gnt",       32'(bus.gnt),       32'h0);
      check("reset done",      32'(bus.done),      32'h0);
      check("reset err",       32'(bus.err),       32'h0);
      check("reset rdata",     32'(bus.rdata),     32'h0);
      check("reset mem_req",   32'(bus.mem_req),   32'h0);
      check("reset mem_we",    32'(bus.mem_we),    32'h0);
      check("reset mem_addr",  32'(bus.mem_addr),  32'h0);
      check("reset mem_wdata", 32'(bus.mem_wdata), 32'h0);
      reset = 1'b0;

      // Table of single transactions from IDLE.
      for (int i = 0; i < 6; i++) begin
         mem_lat = vecs[i].lat;
         drive_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (!bus.mem_req && cyc < 8);
         check($sformatf("v%0d req->mem_req cycles", i), 32'(cyc), 32'd1);
         check($sformatf("v%0d gnt", i),       32'(bus.gnt),       32'(1 << vecs[i].port));
         check($sformatf("v%0d mem_we", i),    32'(bus.mem_we),    32'(vecs[i].we));
         check($sformatf("v%0d mem_addr", i),  32'(bus.mem_addr),  32'(vecs[i].addr));
         check($sformatf("v%0d mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].wdata));
         stable = 1'b1;
         total  = cyc;
         while (bus.done == '0 && total < 200) begin
            @(negedge clk);
            total++;
            if (bus.mem_req && (bus.mem_addr !== vecs[i].addr || bus.mem_we !== vecs[i].we ||
                                bus.mem_wdata !== vecs[i].wdata))
               stable = 1'b0;
         end
         check($sformatf("v%0d mem bus stable", i),    32'(stable),      32'd1);
         check($sformatf("v%0d req->done cycles", i),  32'(total),       32'(vecs[i].lat + 1));
         check($sformatf("v%0d done", i),              32'(bus.done),    32'(1 << vecs[i].port));
         check($sformatf("v%0d gnt in done cycle", i), 32'(bus.gnt),     32'h0);
         check($sformatf("v%0d rdata", i),             32'(bus.rdata),   32'(vecs[i].exp_rdata));
         check($sformatf("v%0d err", i),               32'(bus.err),     32'h0);
         bus.req[vecs[i].port] = 1'b0;
         @(negedge clk);
         check($sformatf("v%0d done single pulse", i), 32'(bus.done),    32'h0);
      end

      // Round-robin: all ports request together right after reset.
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      mem_lat = 1;
      for (int p = 0; p < NR; p++) drive_req(p, 1'b0, AW'(16'h0100 + p), '0);
      for (int k = 0; k < 6; k++) begin
         wait_done(cyc, 20);
         check($sformatf("rr%0d done", k),   32'(bus.done),  32'(1 << (k % 3)));
         check($sformatf("rr%0d gnt", k),    32'(bus.gnt),   32'h0);
         check($sformatf("rr%0d rdata", k),  32'(bus.rdata), 32'(16'(~(16'h0100 + (k % 3)))));
         if (k == 5) begin
            bus.req = '0;
         end else begin
            @(negedge clk);
            check($sformatf("rr%0d next gnt", k), 32'(bus.gnt), 32'(1 << ((k + 1) % 3)));
         end
      end
      @(negedge clk);

      // Timeout on port 0 while port 2 waits; rdata must survive the abort.
      mem_lat = 0;
      drive_req(0, 1'b0, 16'h0300, '0);
      drive_req(2, 1'b0, 16'h3000, '0);
      @(negedge clk);
      check("tmo gnt", 32'(bus.gnt), 32'h1);
      hi_cnt = bus.mem_req ? 1 : 0;
      cyc    = 0;
      while (bus.done == '0 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.mem_req) hi_cnt++;
      end
      check("tmo mem_req cycles", 32'(hi_cnt),    32'(TMO));
      check("tmo done",           32'(bus.done),  32'h1);
      check("tmo err",            32'(bus.err),   32'h1);
      check("tmo rdata kept",     32'(bus.rdata), 32'hFEFD);
      bus.req[0] = 1'b0;
      mem_lat    = 1;
      @(negedge clk);
      check("tmo next gnt",   32'(bus.gnt),  32'h4);
      check("tmo err pulse",  32'(bus.err),  32'h0);
      check("tmo done pulse", 32'(bus.done), 32'h0);
      wait_done(cyc, 20);
      check("post-tmo done",  32'(bus.done),  32'h4);
      check("post-tmo rdata", 32'(bus.rdata), 32'h1234);
      check("post-tmo err",   32'(bus.err),   32'h0);
      bus.req[2] = 1'b0;
      @(negedge clk);

      // Reset in BUSY cycle 3 abandons the transaction without done.
      mem_lat = 0;
      drive_req(1, 1'b0, 16'h0400, '0);
      @(negedge clk);
      check("rst busy mem_req", 32'(bus.mem_req), 32'h1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst mid mem_req", 32'(bus.mem_req), 32'h0);
      check("rst mid gnt",     32'(bus.gnt),     32'h0);
      check("rst mid done",    32'(bus.done),    32'h0);
      bus.req = '0;
      @(negedge clk);
      check("rst mid no done", 32'(bus.done), 32'h0);
      reset   = 1'b0;
      mem_lat = 1;
      for (int p = 0; p < NR; p++) drive_req(p, 1'b0, AW'(16'h0500 + p), '0);
      @(negedge clk);
      check("rst port0 first", 32'(bus.gnt), 32'h1);
      wait_done(cyc, 20);
      check("rst port0 done",  32'(bus.done),  32'h1);
      check("rst port0 rdata", 32'(bus.rdata), 32'hFAFF);
      bus.req = '0;
      @(negedge clk);

      // Stall fairness: port 0 keeps requesting, memory takes 5 cycles.
      mem_lat = 5;
      drive_req(0, 1'b0, 16'h0200, '0);
      @(negedge clk);
      check("stall first gnt", 32'(bus.gnt), 32'h1);
      drive_req(1, 1'b0, 16'h0201, '0);
      drive_req(2, 1'b0, 16'h0202, '0);
      order = '{0, 1, 2, 0};
      for (int t = 0; t < 4; t++) begin
         wait_done(cyc, 40);
         check($sformatf("stall%0d done", t),  32'(bus.done),  32'(1 << order[t]));
         check($sformatf("stall%0d rdata", t), 32'(bus.rdata), 32'(16'(~(16'h0200 + order[t]))));
         check($sformatf("stall%0d err", t),   32'(bus.err),   32'h0);
         if (t == 3) bus.req = '0;
         else if (order[t] != 0) bus.req[order[t]] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check("final idle gnt",     32'(bus.gnt),     32'h0);
      check("final idle mem_req", 32'(bus.mem_req), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
